id_ex_stage: RTL and testbench

- ID/EX pipeline boundary of the 5-stage 64-bit RISC-V core, directly downstream of the register file.
- Captures ReadData1/ReadData2 and decoded control/immediate fields from ID, and presents them registered to EX.
- Contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble.
- Handles branch flush and downstream hold, and keeps a saturating stall counter for bring-up.

---
 rtl/core_pkg.sv | 29 ++
 rtl/id_ex_stage_hazard_detect.sv | 35 +++
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the 5-stage RV64 core pipeline.
//   XLEN       - datapath width (read data, immediate, pc)
//   REG_W      - register specifier width
//   alu_op_e   - ALU operation class decoded in ID
//   id_ex_ctrl_t - control bundle carried across the ID/EX boundary
package core_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,  // address/immediate add
        ALU_BRANCH = 2'b01,  // branch compare (subtract)
        ALU_FUNCT  = 2'b10   // R-type, operation chosen by funct fields
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    alu_src;
        alu_op_e alu_op;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use hazard detection for the ID/EX boundary.
// Inputs : ex_valid, ex_mem_read, ex_rd        - instruction currently in EX
//          id_valid, id_rs1, id_rs2, id_uses_rs2 - instruction currently in ID
//          flush, hold                         - branch kill / downstream freeze
// Outputs: load_use - EX load produces a register the ID instruction reads
//          stall    - freeze PC and IF/ID this cycle
module hazard_detect
    import core_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             flush,
    input  logic             hold,
    output logic             load_use,
    output logic             stall
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a dependency, and rs2 only matters when it is really read.
    assign rs1_hit  = (ex_rd == id_rs1);
    assign rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                      && (rs1_hit || rs2_hit);

    // A taken branch kills the ID instruction anyway, so there is nothing to wait for.
    assign stall    = hold || (load_use && !flush);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV64 core.
// Inputs : clk, reset (async, active-low), id_* decoded instruction fields and
//          register file read data, flush (branch taken in EX), hold (MEM stall).
// Outputs: stall (combinational, freezes PC and IF/ID), ex_* registered fields
//          for EX, stall_count (saturating count of load-use bubbles).
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_read_data1,
    input  logic [XLEN-1:0]  id_read_data2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic             id_alu_src,
    input  logic [1:0]       id_alu_op,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic             ex_valid,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rd,
    output logic [XLEN-1:0]  ex_read_data1,
    output logic [XLEN-1:0]  ex_read_data2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic [CNT_W-1:0] stall_count
);

    logic             valid_q, valid_d;
    logic [REG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]  data1_q, data1_d, data2_q, data2_d, imm_q, imm_d, pc_q, pc_d;
    id_ex_ctrl_t      ctrl_q, ctrl_d, id_ctrl;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    hazard_detect u_hazard (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .flush       (flush),
        .hold        (hold),
        .load_use    (load_use),
        .stall       (stall)
    );

    always_comb begin
        id_ctrl = '{reg_write:  id_reg_write,
                    mem_read:   id_mem_read,
                    mem_write:  id_mem_write,
                    mem_to_reg: id_mem_to_reg,
                    branch:     id_branch,
                    alu_src:    id_alu_src,
                    alu_op:     alu_op_e'(id_alu_op)};
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so
        // no path through this block leaves a signal unassigned (no latches).
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        if (!hold) begin
            if (flush || load_use) begin
                // Bubble: only valid and control are cleared; data fields are
                // don't-care for a dead slot, so they simply hold.
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else begin
                valid_d = id_valid;
                rs1_d   = id_rs1;
                rs2_d   = id_rs2;
                rd_d    = id_rd;
                data1_d = id_read_data1;
                data2_d = id_read_data2;
                imm_d   = id_imm;
                pc_d    = id_pc;
                ctrl_d  = id_valid ? id_ctrl : '0;
                if (id_rd == '0) ctrl_d.reg_write = 1'b0;
            end

            if (load_use && !flush && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_read_data1 = data1_q;
    assign ex_read_data2 = data2_q;
    assign ex_imm        = imm_q;
    assign ex_pc         = pc_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// behavioural model of the ID/EX boundary. A second instance with a 2-bit
// counter shares the stimulus so counter saturation is reachable.
module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, id_uses_rs2;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_read_data1, id_read_data2, id_imm, id_pc;
    logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src;
    logic [1:0]      id_alu_op;
    logic            flush, hold;

    logic            stall, ex_valid;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_read_data1, ex_read_data2, ex_imm, ex_pc;
    logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src;
    logic [1:0]      ex_alu_op;
    logic [31:0]     stall_count;

    logic            s_stall, s_ex_valid;
    logic [4:0]      s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [XLEN-1:0] s_ex_read_data1, s_ex_read_data2, s_ex_imm, s_ex_pc;
    logic            s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg, s_ex_branch, s_ex_alu_src;
    logic [1:0]      s_ex_alu_op;
    logic [1:0]      s_stall_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_read_data1(id_read_data1),
        .id_read_data2(id_read_data2), .id_imm(id_imm), .id_pc(id_pc),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_read_data1(id_read_data1),
        .id_read_data2(id_read_data2), .id_imm(id_imm), .id_pc(id_pc),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .flush(flush), .hold(hold), .stall(s_stall),
        .ex_valid(s_ex_valid), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_read_data1(s_ex_read_data1), .ex_read_data2(s_ex_read_data2), .ex_imm(s_ex_imm),
        .ex_pc(s_ex_pc), .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
        .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg), .ex_branch(s_ex_branch),
        .ex_alu_src(s_ex_alu_src), .ex_alu_op(s_ex_alu_op), .stall_count(s_stall_count)
    );

    // ---------------- behavioural model: what EX should be holding ----------------
    typedef struct {
        bit              valid;
        bit [4:0]        rs1, rs2, rd;
        bit [XLEN-1:0]   d1, d2, imm, pc;
        bit              rw, mr, mw, m2r, br, as;
        bit [1:0]        op;
        longint unsigned cnt;
    } ex_model_t;

    ex_model_t m;

    function automatic void model_reset();
        m = '{default: 0};
    endfunction

    // Does the instruction in ID need a value the load in EX has not produced yet?
    function automatic bit model_load_use();
        bit reads_it;
        reads_it = (id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        return m.valid && m.mr && m.rd != 0 && id_valid && reads_it;
    endfunction

    function automatic bit model_stall();
        return hold || (model_load_use() && !flush);
    endfunction

    // Advance the model by one clock edge using the current ID inputs.
    function automatic void model_step();
        bit lu;
        lu = model_load_use();
        if (hold) return;
        if (lu && !flush && m.cnt < 64'hFFFF_FFFF) m.cnt++;
        if (flush || lu) begin
            m.valid = 0;
            {m.rw, m.mr, m.mw, m.m2r, m.br, m.as, m.op} = '0;
            return;
        end
        m.valid = id_valid;
        m.rs1 = id_rs1;  m.rs2 = id_rs2;  m.rd = id_rd;
        m.d1 = id_read_data1;  m.d2 = id_read_data2;  m.imm = id_imm;  m.pc = id_pc;
        if (id_valid) begin
            m.rw = id_reg_write && (id_rd != 0);
            m.mr = id_mem_read;  m.mw = id_mem_write;  m.m2r = id_mem_to_reg;
            m.br = id_branch;    m.as = id_alu_src;    m.op = id_alu_op;
        end else begin
            {m.rw, m.mr, m.mw, m.m2r, m.br, m.as, m.op} = '0;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        longint unsigned small_exp;
        small_exp = (m.cnt > 3) ? 3 : m.cnt;
        check({tag, ".valid"}, 64'(ex_valid), 64'(m.valid));
        check({tag, ".ctrl"},
              64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src, ex_alu_op}),
              64'({m.rw, m.mr, m.mw, m.m2r, m.br, m.as, m.op}));
        check({tag, ".regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m.rs1, m.rs2, m.rd}));
        check({tag, ".data1"}, ex_read_data1, m.d1);
        check({tag, ".data2"}, ex_read_data2, m.d2);
        check({tag, ".imm"}, ex_imm, m.imm);
        check({tag, ".pc"}, ex_pc, m.pc);
        check({tag, ".count"}, 64'(stall_count), m.cnt);
        check({tag, ".count_small"}, 64'(s_stall_count), small_exp);
        check({tag, ".small_valid"}, 64'(s_ex_valid), 64'(m.valid));
    endtask

    // One clock: check stall mid-cycle, take the edge, check the registered outputs.
    task automatic cycle(input string tag);
        @(negedge clk);
        check({tag, ".stall"}, 64'(stall), 64'(model_stall()));
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_instr(input bit v, input int rs1, input int rs2, input int rd,
                             input bit uses2, input bit rw, input bit mr);
        id_valid = v;  id_rs1 = 5'(rs1);  id_rs2 = 5'(rs2);  id_rd = 5'(rd);
        id_uses_rs2 = uses2;  id_reg_write = rw;  id_mem_read = mr;  id_mem_to_reg = mr;
        id_mem_write = 1'b0;  id_branch = 1'b0;  id_alu_src = mr;  id_alu_op = 2'b00;
        id_read_data1 = {$urandom(), $urandom()};
        id_read_data2 = {$urandom(), $urandom()};
        id_imm = {$urandom(), $urandom()};
        id_pc  = {32'h0, $urandom()} & ~64'h3;
    endtask

    task automatic rand_instr();
        id_valid = ($urandom_range(0, 7) != 0);
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        id_rd  = 5'($urandom_range(0, 3));
        id_uses_rs2 = 1'($urandom);
        {id_reg_write, id_mem_write, id_mem_to_reg, id_branch, id_alu_src} = 5'($urandom);
        id_mem_read = ($urandom_range(0, 2) == 0);
        id_alu_op = 2'($urandom_range(0, 2));
        id_read_data1 = {$urandom(), $urandom()};
        id_read_data2 = {$urandom(), $urandom()};
        id_imm = {$urandom(), $urandom()};
        id_pc  = {$urandom(), $urandom()};
        flush = ($urandom_range(0, 9) == 0);
        hold  = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset.stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Plain issue: one-cycle latency, everything captured.
        set_instr(1, 5, 6, 7, 1, 1, 0);
        id_read_data1 = 64'h10;
        id_read_data2 = 64'h20;
        cycle("plain");
        check("plain.rd", 64'(ex_rd), 64'd7);
        check("plain.data1", ex_read_data1, 64'h10);
        check("plain.rw", 64'(ex_reg_write), 64'd1);

        // Load-use on rs1: one bubble, then the add issues.
        set_instr(1, 1, 2, 9, 0, 1, 1);  cycle("ld9");
        set_instr(1, 9, 3, 10, 1, 1, 0);
        cycle("lu_bubble");
        check("lu_bubble.valid", 64'(ex_valid), 64'd0);
        cycle("lu_issue");
        check("lu_issue.rd", 64'(ex_rd), 64'd10);
        check("lu_issue.count", 64'(stall_count), 64'd1);

        // rs2 dependency only counts when rs2 is really read.
        set_instr(1, 1, 2, 9, 0, 1, 1);  cycle("ld9_b");
        set_instr(1, 2, 9, 11, 0, 1, 0); cycle("rs2_unused");
        set_instr(1, 1, 2, 9, 0, 1, 1);  cycle("ld9_c");
        set_instr(1, 2, 9, 12, 1, 1, 0); cycle("rs2_bubble");
        cycle("rs2_issue");

        // x0: no dependency through x0; rd=0 never writes.
        set_instr(1, 1, 2, 0, 0, 1, 1);  cycle("ld_x0");
        set_instr(1, 0, 0, 13, 1, 1, 0); cycle("use_x0");
        set_instr(1, 3, 4, 0, 1, 1, 0);  cycle("rd_x0");
        check("rd_x0.rw", 64'(ex_reg_write), 64'd0);

        // flush with load_use: bubble, no stall, count unchanged.
        set_instr(1, 1, 2, 9, 0, 1, 1);  cycle("ld9_d");
        set_instr(1, 9, 3, 14, 1, 1, 0);
        flush = 1'b1;                    cycle("flush_lu");
        flush = 1'b0;
        // hold with flush: everything frozen, stall asserted.
        set_instr(1, 1, 2, 9, 0, 1, 1);  cycle("ld9_e");
        hold = 1'b1;  flush = 1'b1;      cycle("hold_flush");
        hold = 1'b0;  flush = 1'b0;      cycle("hold_release");

        // Saturation of the 2-bit instance: several dependent load pairs.
        for (int i = 0; i < 5; i++) begin
            set_instr(1, 1, 2, 9, 0, 1, 1); cycle("sat_ld");
            set_instr(1, 9, 9, 15, 1, 1, 0); cycle("sat_bubble");
            cycle("sat_issue");
        end
        check("sat.count_small", 64'(s_stall_count), 64'd3);

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rand_instr();
            cycle("rand");
        end

        // Async reset between edges, in the middle of a load-use stall.
        flush = 1'b0;  hold = 1'b0;
        set_instr(1, 1, 2, 9, 0, 1, 1);  cycle("pre_rst_ld");
        set_instr(1, 9, 3, 16, 1, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        check("mid_reset.stall", 64'(stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle("post_reset");
        check("post_reset.rd", 64'(ex_rd), 64'd16);
        check("post_reset.valid", 64'(ex_valid), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
